// File: rtl/apb_slave_fifo_if.sv
// rtl/apb_slave_fifo_if.sv - APB3 bus bundle between the bridge master and apb_slave_fifo
interface apb_slave_fifo_if #(
    parameter int ADD_W  = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADD_W-1:0]  paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_fifo.sv
// rtl/apb_slave_fifo.sv - APB3 register/FIFO front end of the I2C bridge; APB_SLV_WAIT_EN adds LFSR wait states
module apb_slave_fifo #(
    parameter int               ADD_W      = 8,
    parameter int               DATA_W     = 8,
    parameter logic [ADD_W-1:0] BASE_ADDR  = ADD_W'(8'hF0),
    parameter int               FIFO_DEPTH = 8,
    parameter int               MAX_WAIT   = 3
) (
    input  logic              pclk,
    input  logic              preset,
    apb_slave_fifo_if.slave   apb,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              irq
);
    localparam int         AW   = $clog2(FIFO_DEPTH);
    localparam int         PW   = AW + 1;
    localparam logic [2:0] WMAX = 3'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t     state_q, state_d, phase;
    logic [2:0] wcnt_q, wcnt_d;
    logic [2:0] raw_wait, waits;
    logic       pready_c;

    // ---------------- wait-state source ----------------
`ifdef APB_SLV_WAIT_EN
    logic [6:0] lfsr_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            lfsr_q <= 7'b1101011;
        end else if (phase == SETUP && apb.psel) begin
            lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    assign raw_wait = lfsr_q[2:0];
`else
    assign raw_wait = 3'd0;
`endif

    assign waits = (raw_wait > WMAX) ? WMAX : raw_wait;

    // ---------------- transfer FSM ----------------
    // A setup cycle arriving in IDLE is handled as SETUP in that same cycle,
    // so a zero-wait transfer completes in its second cycle.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && apb.psel && !apb.penable) begin
            phase = SETUP;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pready_c = 1'b0;
        case (phase)
            IDLE: begin
                state_d = IDLE;
            end
            SETUP: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    wcnt_d  = waits;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (wcnt_q != 3'd0) begin
                    wcnt_d = wcnt_q - 3'd1;
                end else begin
                    pready_c = 1'b1;
                    state_d  = (apb.psel && !apb.penable) ? SETUP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // ---------------- decode and error checks ----------------
    logic              hit, complete, err_c, ok;
    logic [1:0]        off;
    logic [DATA_W-1:0] rdata_c;
    logic              ctrl_en, ctrl_irq_en, err_sticky;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic [DATA_W-1:0] rx_head;
    logic              wr_ctrl, tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;

    assign hit      = (apb.paddr[ADD_W-1:2] == BASE_ADDR[ADD_W-1:2]);
    assign off      = apb.paddr[1:0];
    assign complete = apb.psel && apb.penable && pready_c;

    always_comb begin
        err_c = 1'b0;
        if (!hit) begin
            err_c = 1'b1;
        end else begin
            case (off)
                2'd0:    err_c = 1'b0;
                2'd1:    err_c = apb.pwrite;
                2'd2:    err_c = !apb.pwrite || tx_full;
                default: err_c = apb.pwrite || rx_empty;
            endcase
        end
    end

    always_comb begin
        rdata_c = '0;
        case (off)
            2'd0:    rdata_c = DATA_W'({ctrl_irq_en, 2'b00, ctrl_en});
            2'd1:    rdata_c = DATA_W'({err_sticky, rx_full, rx_empty, tx_full, tx_empty});
            2'd3:    rdata_c = rx_head;
            default: rdata_c = '0;
        endcase
    end

    assign apb.pready  = pready_c;
    assign apb.pslverr = pready_c && err_c;
    assign apb.prdata  = (pready_c && !err_c && !apb.pwrite) ? rdata_c : '0;

    assign ok       = complete && !err_c;
    assign wr_ctrl  = ok && apb.pwrite && (off == 2'd0);
    assign tx_push  = ok && apb.pwrite && (off == 2'd2);
    assign rx_pop   = ok && !apb.pwrite && (off == 2'd3);
    assign tx_flush = wr_ctrl && apb.pwdata[1];
    assign rx_flush = wr_ctrl && apb.pwdata[2];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            err_sticky  <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= apb.pwdata[0];
                ctrl_irq_en <= apb.pwdata[3];
                if (apb.pwdata[7]) begin
                    err_sticky <= 1'b0;
                end
            end
            if (complete && err_c) begin
                err_sticky <= 1'b1;
            end
            irq <= ctrl_irq_en && !rx_empty;
        end
    end

    // ---------------- TX FIFO (APB -> I2C) ----------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]     tx_wp, tx_rp;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_valid = !tx_empty && ctrl_en;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_data  = tx_empty ? '0 : tx_mem[tx_rp[AW-1:0]];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else if (tx_flush) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + PW'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (tx_push) begin
            tx_mem[tx_wp[AW-1:0]] <= apb.pwdata;
        end
    end

    // ---------------- RX FIFO (I2C -> APB) ----------------
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]     rx_wp, rx_rp;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_head  = rx_mem[rx_rp[AW-1:0]];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else if (rx_flush) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + PW'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (rx_push) begin
            rx_mem[rx_wp[AW-1:0]] <= rx_data;
        end
    end
endmodule

// File: tb/tb_apb_slave_fifo.sv
// tb/tb_apb_slave_fifo.sv - scoreboard bench for apb_slave_fifo; APB_SLV_WAIT_EN selects the LFSR wait model
module tb_apb_slave_fifo;
    logic       pclk = 1'b0;
    logic       preset;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       err;
        logic [7:0] rd;
        int         waits;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic [6:0] m_lfsr;

    apb_slave_fifo_if #(.ADD_W(8), .DATA_W(8)) bus ();

    apb_slave_fifo #(
        .ADD_W(8), .DATA_W(8), .BASE_ADDR(8'hF0), .FIFO_DEPTH(8), .MAX_WAIT(3)
    ) dut (
        .pclk(pclk), .preset(preset), .apb(bus.slave),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int next_waits();
        int w;
`ifdef APB_SLV_WAIT_EN
        w = int'(m_lfsr[2:0]);
        if (w > 3) w = 3;
        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
`else
        w = 0;
`endif
        return w;
    endfunction

    // APB master: queues the expected response, then runs the transfer.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                       input logic e_err, input logic [7:0] e_rd, input string name);
        exp_t e;
        int   n;
        e.name = name; e.err = e_err; e.rd = e_rd; e.waits = next_waits();
        exp_q.push_back(e);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = data;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        n = 0;
        forever begin
            @(negedge pclk);
            if (bus.pready || n >= 16) break;
            @(posedge pclk); #1;
            n++;
        end
        if (!bus.pready) begin
            checks++; errors++;
            $display("FAIL %s_timeout: pready=0 after %0d cycles, required 1", name, n);
            void'(exp_q.pop_back());
        end
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] d);
        @(posedge pclk); #1;
        rx_valid = 1'b1; rx_data = d;
        @(posedge pclk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pready"},   32'(bus.pready),  32'd0);
        chk({tag, "_pslverr"},  32'(bus.pslverr), 32'd0);
        chk({tag, "_prdata"},   32'(bus.prdata),  32'd0);
        chk({tag, "_tx_data"},  32'(tx_data),     32'd0);
        chk({tag, "_tx_valid"}, 32'(tx_valid),    32'd0);
        chk({tag, "_rx_ready"}, 32'(rx_ready),    32'd1);
        chk({tag, "_irq"},      32'(irq),         32'd0);
    endtask

    // APB response monitor: compares every completing cycle against the queue.
    initial begin
        int   cyc;
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge pclk);
            if (preset || !bus.psel) begin
                cyc = 0;
            end else begin
                cyc++;
                if (bus.penable && bus.pready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_completion: got pready=1, required no transfer");
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_pslverr"}, 32'(bus.pslverr), 32'(e.err));
                        chk({e.name, "_prdata"},  32'(bus.prdata),  32'(e.rd));
                        chk({e.name, "_cycles"},  32'(cyc),         32'(2 + e.waits));
                    end
                    cyc = 0;
                end
            end
        end
    end

    // TX stream monitor.
    initial begin
        forever begin
            @(negedge pclk);
            if (!preset && tx_valid && tx_ready) begin
                if (tx_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got 0x%0h, required no pop", tx_data);
                end else begin
                    chk("tx_data", 32'(tx_data), 32'(tx_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exhausted, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        preset = 1'b1; m_lfsr = 7'b1101011;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge pclk);
        check_reset_outputs("reset");
        @(posedge pclk); #1;
        preset = 1'b0;

        apb(1, 8'hF1, 8'h00, 1, 8'h00, "status_wr_first");
        apb(1, 8'hF0, 8'h81, 0, 8'h00, "ctrl_wr_clr");
        apb(0, 8'hF1, 8'h00, 0, 8'h05, "status_reset");
        apb(1, 8'hF0, 8'h01, 0, 8'h00, "ctrl_wr");
        apb(0, 8'hF0, 8'h00, 0, 8'h01, "ctrl_rd");

        for (int i = 0; i < 8; i++) begin
            apb(1, 8'hF2, 8'(8'h10 + i), 0, 8'h00, "tx_push");
            tx_exp_q.push_back(8'(8'h10 + i));
        end
        apb(0, 8'hF1, 8'h00, 0, 8'h06, "status_tx_full");
        @(negedge pclk);
        chk("tx_valid_full", 32'(tx_valid), 32'd1);
        chk("tx_head_full",  32'(tx_data),  32'h10);
        apb(1, 8'hF2, 8'h18, 1, 8'h00, "tx_push_full");
        apb(0, 8'hF1, 8'h00, 0, 8'h16, "status_sticky");

        @(posedge pclk); #1;
        tx_ready = 1'b1;
        n = 0;
        do begin @(negedge pclk); n++; end while (tx_valid && n < 40);
        chk("tx_drained", 32'(tx_valid), 32'd0);
        @(posedge pclk); #1;
        tx_ready = 1'b0;
        apb(0, 8'hF1, 8'h00, 0, 8'h15, "status_drained");
        apb(1, 8'hF0, 8'h81, 0, 8'h00, "ctrl_clr_sticky");
        apb(0, 8'hF0, 8'h00, 0, 8'h01, "ctrl_rd_bit7");
        apb(0, 8'hF1, 8'h00, 0, 8'h05, "status_cleared");

        rx_send(8'hA5);
        rx_send(8'h5A);
        apb(0, 8'hF1, 8'h00, 0, 8'h01, "status_rx_data");
        apb(1, 8'hF0, 8'h09, 0, 8'h00, "ctrl_irq_en");
        repeat (2) @(negedge pclk);
        chk("irq_set", 32'(irq), 32'd1);
        apb(0, 8'hF3, 8'h00, 0, 8'hA5, "rx_pop0");
        apb(0, 8'hF3, 8'h00, 0, 8'h5A, "rx_pop1");
        repeat (2) @(negedge pclk);
        chk("irq_clear", 32'(irq), 32'd0);
        apb(0, 8'hF3, 8'h00, 1, 8'h00, "rx_pop_empty");
        apb(0, 8'hF1, 8'h00, 0, 8'h15, "status_rx_empty");

        apb(0, 8'h00, 8'h00, 1, 8'h00, "nonhit_rd");
        apb(1, 8'h00, 8'h00, 1, 8'h00, "nonhit_wr");
        apb(0, 8'hF4, 8'h00, 1, 8'h00, "nonhit_f4");
        apb(1, 8'hF1, 8'hFF, 1, 8'h00, "status_wr");
        apb(1, 8'hF3, 8'hFF, 1, 8'h00, "rxdata_wr");
        apb(0, 8'hF2, 8'h00, 1, 8'h00, "txdata_rd");
        apb(0, 8'hF0, 8'h00, 0, 8'h09, "ctrl_unchanged");

        apb(1, 8'hF2, 8'hAA, 0, 8'h00, "tx_push_aa");
        apb(1, 8'hF2, 8'hBB, 0, 8'h00, "tx_push_bb");
        apb(0, 8'hF1, 8'h00, 0, 8'h14, "status_pre_flush");
        apb(1, 8'hF0, 8'h0B, 0, 8'h00, "ctrl_tx_flush");
        apb(0, 8'hF1, 8'h00, 0, 8'h15, "status_flushed");
        apb(0, 8'hF0, 8'h00, 0, 8'h09, "ctrl_flush_reads0");
        @(negedge pclk);
        chk("tx_valid_flushed", 32'(tx_valid), 32'd0);

        for (int i = 0; i < 20; i++) begin
            apb(0, 8'hF1, 8'h00, 0, 8'h15, "status_loop");
        end

        for (int i = 0; i < 3; i++) begin
            apb(1, 8'hF2, 8'(8'h31 + i), 0, 8'h00, "tx_push_pre_rst");
        end
        apb(0, 8'hF1, 8'h00, 0, 8'h14, "status_pre_rst");
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'hF2; bus.pwdata = 8'h34;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #2;
        preset = 1'b1;
        m_lfsr = 7'b1101011;
        @(negedge pclk);
        check_reset_outputs("midrst");
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        apb(0, 8'hF1, 8'h00, 0, 8'h05, "status_post_rst");
        apb(0, 8'hF0, 8'h00, 0, 8'h00, "ctrl_post_rst");

        repeat (3) @(negedge pclk);
        chk("exp_queue_empty", 32'(exp_q.size()),    32'd0);
        chk("tx_queue_empty",  32'(tx_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
